pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL provide the following ports, one per line as name, direction, width and meaning; reset is asynchronous, active-low, and the clock is clk.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low.
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  in  1 each  the ID instruction reads that source.
- ID_Jump  in  1  j/jal/jr resolved in ID.
- EX_Rw, MEM_Rw  in  5 each  resolved destination register in the EX and MEM stages.
- EX_RegWr, MEM_RegWr  in  1 each  destination write enable in the EX and MEM stages.
- EX_MemRd  in  1  the EX instruction is a load.
- EX_BranchTaken  in  1  branch resolved taken in EX.
- IRQ  in  1  level interrupt request.
- ERet  in  1  return-from-interrupt executing in ID.
- PC_Wr  out  1  PC update enable.
- IF_ID_Stall  out  1  IF_ID register holds its value.
- IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  load a bubble into that register.
- IRQ_Take  out  1  select the interrupt vector into PC this cycle.
- InKernel  out  1  interrupt handler active.
- FwdA, FwdB  out  2 each  registered EX-stage operand select: 00 = register file, 01 = EX_MEM ALUOut, 10 = MEM_WB write data.

Function
REQ-002 The FSM SHALL have exactly three states: RUN, STALL and IRQ.
REQ-003 The control outputs PC_Wr, stall, flush and IRQ_Take SHALL be combinational from the state and the inputs; FwdA, FwdB and InKernel SHALL be registered.
REQ-004 A match on a source SHALL mean (ID_UsesRs and ID_Rs==X) or (ID_UsesRt and ID_Rt==X), with X nonzero; register 0 never matches.
REQ-005 The register file is write-before-read, so a WB-stage destination SHALL never cause a hazard.
REQ-006 Default outputs in RUN with no event SHALL be PC_Wr=1 and all stalls, flushes and IRQ_Take equal to 0.
REQ-007 During a stall cycle the block SHALL drive PC_Wr=0, IF_ID_Stall=1, ID_EX_Flush=1 and IF_ID_Flush=0.
REQ-008 When ID_Jump=1 in RUN with no stall condition, the block SHALL drive IF_ID_Flush=1 for one cycle.
REQ-009 A stall SHALL take priority over a jump, so the jump is honoured only in the cycle its operands are hazard-free.
REQ-010 When EX_BranchTaken=1 in any state, the block SHALL drive IF_ID_Flush=1, ID_EX_Flush=1, IF_ID_Stall=0 and PC_Wr=1, and the next state SHALL be RUN with the stall counter cleared.
REQ-011 EX_BranchTaken SHALL override both stall and jump.
REQ-012 IRQ SHALL be sampled only in RUN with InKernel=0, no stall condition and EX_BranchTaken=0; when sampled, the next state SHALL be IRQ.
REQ-013 The IRQ state SHALL last exactly one cycle and drive IRQ_Take=1, PC_Wr=1, IF_ID_Flush=1 and ID_EX_Flush=1; the next state is RUN and InKernel is set to 1.
REQ-014 ERet=1 while InKernel=1 SHALL clear InKernel at the next edge.
REQ-015 If ERet=1 and IRQ=1 in the same cycle, the block SHALL take no IRQ that cycle; the IRQ becomes eligible on the following cycle.
REQ-016 EX_MEM_Flush SHALL assert only while reset is low.

Reset
REQ-017 While reset is low, outputs SHALL be PC_Wr=0, IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, IF_ID_Stall=0, IRQ_Take=0, InKernel=0 and FwdA=FwdB=00.
REQ-018 While reset is low, the state SHALL be RUN and the stall counter 0.
REQ-019 Reset asserted mid-stall or in the IRQ state SHALL abort that stall or interrupt entry immediately, with no pending IRQ remembered.

Configuration
REQ-020 With macro PIPELINE_FORWARD_EN defined, the stall condition SHALL be EX_MemRd and EX_RegWr and a match on EX_Rw, giving exactly one STALL cycle.
REQ-021 With PIPELINE_FORWARD_EN defined, FwdA and FwdB SHALL be loaded on each non-stall edge as follows:
- 01 on a match on EX_Rw with EX_RegWr and not EX_MemRd.
- Otherwise 10 on a match on MEM_Rw with MEM_RegWr.
- Otherwise 00.
- The EX match has priority over the MEM match.
REQ-022 On a stall edge with PIPELINE_FORWARD_EN defined, FwdA and FwdB SHALL load 00, because the bubble enters EX.
REQ-023 Without PIPELINE_FORWARD_EN, FwdA and FwdB SHALL be constant 00.
REQ-024 Without PIPELINE_FORWARD_EN, the stall condition SHALL be any match on EX_Rw with EX_RegWr, which loads the 2-bit counter with 2, or on MEM_Rw with MEM_RegWr, which loads it with 1.
REQ-025 Without PIPELINE_FORWARD_EN, the block SHALL stay in STALL, decrementing the counter each edge, until the counter reaches 0, then return to RUN.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- lw writing $8 in EX and add in ID reading $8, with PIPELINE_FORWARD_EN defined -> exactly 1 cycle with PC_Wr=0 and ID_EX_Flush=1, then FwdA=10 with the add in EX.
- add writing $8 in EX and sub in ID reading $8 as Rt, with PIPELINE_FORWARD_EN defined -> no stall, and FwdB=01 next cycle.
- The same add/sub pair without PIPELINE_FORWARD_EN -> 2 stall cycles, then PC_Wr=1.
- EX_BranchTaken=1 during the second cycle of a macro-off stall -> IF_ID_Flush=1 and ID_EX_Flush=1 that cycle, with PC_Wr=1 and state RUN next.
- IRQ=1 in RUN -> one cycle of IRQ_Take=1 and InKernel=1 after it; a second IRQ is ignored until ERet=1 pulses.
- reset driven low during the IRQ state -> all flushes equal 1 and IRQ_Take=0 immediately, with InKernel=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/interrupt controller: stall, flush, PC-write and operand-forward selects.
// Optional feature: define PIPELINE_FORWARD_EN to enable EX/MEM operand forwarding (load-use stall only).
module pipeline_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       ID_Jump,
    input  logic [4:0] EX_Rw,
    input  logic [4:0] MEM_Rw,
    input  logic       EX_RegWr,
    input  logic       MEM_RegWr,
    input  logic       EX_MemRd,
    input  logic       EX_BranchTaken,
    input  logic       IRQ,
    input  logic       ERet,
    output logic       PC_Wr,
    output logic       IF_ID_Stall,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_MEM_Flush,
    output logic       IRQ_Take,
    output logic       InKernel,
    output logic [1:0] FwdA,
    output logic [1:0] FwdB
);

    typedef enum logic [1:0] {S_RUN, S_STALL, S_IRQ} state_t;

    state_t     state, state_next;
    logic [1:0] cnt, cnt_next;
    logic [1:0] stall_load;
    logic       stall_cond, stall_now, irq_sample;
    logic       rs_ex, rt_ex, rs_mem, rt_mem, ex_match;

    // Register 0 is hardwired, so it never creates a dependency.
    assign rs_ex    = ID_UsesRs && (ID_Rs != 5'd0) && (ID_Rs == EX_Rw);
    assign rt_ex    = ID_UsesRt && (ID_Rt != 5'd0) && (ID_Rt == EX_Rw);
    assign rs_mem   = ID_UsesRs && (ID_Rs != 5'd0) && (ID_Rs == MEM_Rw);
    assign rt_mem   = ID_UsesRt && (ID_Rt != 5'd0) && (ID_Rt == MEM_Rw);
    assign ex_match = rs_ex || rt_ex;

`ifdef PIPELINE_FORWARD_EN
    logic [1:0] fwd_a_next, fwd_b_next;

    assign stall_cond = EX_MemRd && EX_RegWr && ex_match;
    assign stall_load = 2'd1;

    always_comb begin
        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (rs_ex && EX_RegWr && !EX_MemRd)
            fwd_a_next = 2'b01;
        else if (rs_mem && MEM_RegWr)
            fwd_a_next = 2'b10;
        if (rt_ex && EX_RegWr && !EX_MemRd)
            fwd_b_next = 2'b01;
        else if (rt_mem && MEM_RegWr)
            fwd_b_next = 2'b10;
    end
`else
    logic mem_match;
    logic unused_in;

    assign mem_match  = rs_mem || rt_mem;
    assign unused_in  = EX_MemRd;
    assign stall_cond = (EX_RegWr && ex_match) || (MEM_RegWr && mem_match);
    assign stall_load = (EX_RegWr && ex_match) ? 2'd2 : 2'd1;
`endif

    assign irq_sample = (state == S_RUN) && !InKernel && !stall_cond &&
                        !EX_BranchTaken && IRQ && !ERet;

    assign EX_MEM_Flush = !reset;

    // The detecting RUN cycle is the first stall cycle; STALL covers only the remainder.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        stall_now   = 1'b0;
        PC_Wr       = 1'b1;
        IF_ID_Stall = 1'b0;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        IRQ_Take    = 1'b0;

        case (state)
            S_RUN: begin
                if (stall_cond) begin
                    stall_now  = 1'b1;
                    cnt_next   = stall_load - 2'd1;
                    state_next = (stall_load > 2'd1) ? S_STALL : S_RUN;
                end else begin
                    if (ID_Jump)
                        IF_ID_Flush = 1'b1;
                    if (irq_sample)
                        state_next = S_IRQ;
                end
            end
            S_STALL: begin
                stall_now = 1'b1;
                cnt_next  = cnt - 2'd1;
                if (cnt <= 2'd1)
                    state_next = S_RUN;
            end
            S_IRQ: begin
                IRQ_Take    = 1'b1;
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
                state_next  = S_RUN;
            end
            default: state_next = S_RUN;
        endcase

        if (stall_now) begin
            PC_Wr       = 1'b0;
            IF_ID_Stall = 1'b1;
            ID_EX_Flush = 1'b1;
            IF_ID_Flush = 1'b0;
        end

        if (EX_BranchTaken) begin
            stall_now   = 1'b0;
            PC_Wr       = 1'b1;
            IF_ID_Stall = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_next  = S_RUN;
            cnt_next    = '0;
        end

        if (!reset) begin
            PC_Wr       = 1'b0;
            IF_ID_Stall = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            IRQ_Take    = 1'b0;
            state_next  = S_RUN;
            cnt_next    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RUN;
            cnt      <= '0;
            InKernel <= 1'b0;
            FwdA     <= '0;
            FwdB     <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IRQ)
                InKernel <= 1'b1;
            else if (ERet && InKernel)
                InKernel <= 1'b0;
`ifdef PIPELINE_FORWARD_EN
            // A stall edge pushes a bubble into EX, so nothing is forwarded.
            FwdA <= stall_now ? 2'b00 : fwd_a_next;
            FwdB <= stall_now ? 2'b00 : fwd_b_next;
`else
            FwdA <= '0;
            FwdB <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl; tables adapt to PIPELINE_FORWARD_EN.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rw, MEM_Rw;
    logic       ID_UsesRs, ID_UsesRt, ID_Jump, EX_RegWr, MEM_RegWr, EX_MemRd;
    logic       EX_BranchTaken, IRQ, ERet;
    logic       PC_Wr, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, IRQ_Take, InKernel;
    logic [1:0] FwdA, FwdB;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_Jump(ID_Jump), .EX_Rw(EX_Rw), .MEM_Rw(MEM_Rw), .EX_RegWr(EX_RegWr),
        .MEM_RegWr(MEM_RegWr), .EX_MemRd(EX_MemRd), .EX_BranchTaken(EX_BranchTaken),
        .IRQ(IRQ), .ERet(ERet), .PC_Wr(PC_Wr), .IF_ID_Stall(IF_ID_Stall),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
        .IRQ_Take(IRQ_Take), .InKernel(InKernel), .FwdA(FwdA), .FwdB(FwdB)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs, rt;
        logic       urs, urt, jump;
        logic [4:0] exrw, memrw;
        logic       exwr, memwr, exmrd, br, irq, eret;
    } in_t;

    typedef struct {
        string       name;
        in_t         stim;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    // {PC_Wr, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, IRQ_Take, InKernel, FwdA, FwdB}
    logic [10:0] obs;
    assign obs = {PC_Wr, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
                  IRQ_Take, InKernel, FwdA, FwdB};

    function automatic in_t idle();
        in_t t;
        t     = '0;
        t.rst = 1'b1;
        return t;
    endfunction

    function automatic void add(input string name, input in_t t, input logic [10:0] e);
        vec_t v;
        v.name = name;
        v.stim = t;
        v.exp  = e;
        vecs.push_back(v);
    endfunction

    task automatic apply(input in_t t);
        reset = t.rst; ID_Rs = t.rs; ID_Rt = t.rt; ID_UsesRs = t.urs; ID_UsesRt = t.urt;
        ID_Jump = t.jump; EX_Rw = t.exrw; MEM_Rw = t.memrw; EX_RegWr = t.exwr;
        MEM_RegWr = t.memwr; EX_MemRd = t.exmrd; EX_BranchTaken = t.br; IRQ = t.irq; ERet = t.eret;
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        in_t t;
        int  found;

        t = idle(); t.rst = 1'b0;                                   add("reset", t, 11'b0011100_00_00);
        t = idle();                                                 add("idle", t, 11'b1000000_00_00);
        t = idle(); t.jump = 1;                                     add("jump", t, 11'b1010000_00_00);
        t = idle(); t.irq = 1;                                      add("irq_sample", t, 11'b1000000_00_00);
        t = idle(); t.irq = 1;                                      add("irq_state", t, 11'b1011010_00_00);
        t = idle(); t.irq = 1;                                      add("irq_masked", t, 11'b1000001_00_00);
        t = idle(); t.irq = 1; t.eret = 1;                          add("eret_with_irq", t, 11'b1000001_00_00);
        t = idle(); t.irq = 1;                                      add("irq_again", t, 11'b1000000_00_00);
        t = idle(); t.rst = 1'b0;                                   add("reset_in_irq", t, 11'b0011100_00_00);
        t = idle();                                                 add("after_reset", t, 11'b1000000_00_00);
        t = idle(); t.irq = 1; t.eret = 1;                          add("eret_irq_same", t, 11'b1000000_00_00);
        t = idle();                                                 add("no_irq_next", t, 11'b1000000_00_00);
        t = idle(); t.urs = 1; t.exwr = 1; t.exmrd = 1;             add("r0_no_match", t, 11'b1000000_00_00);
        t = idle(); t.rs = 8; t.exrw = 8; t.exwr = 1; t.exmrd = 1;  add("unused_src", t, 11'b1000000_00_00);
        t = idle();                                                 add("idle_fwd", t, 11'b1000000_00_00);
`ifdef PIPELINE_FORWARD_EN
        t = idle(); t.rs = 8; t.urs = 1; t.exrw = 8; t.exwr = 1; t.exmrd = 1;
        add("lw_hazard", t, 11'b0101000_00_00);
        t = idle(); t.rs = 8; t.urs = 1; t.memrw = 8; t.memwr = 1;
        add("lw_in_mem", t, 11'b1000000_00_00);
        t = idle();                                                 add("add_fwd_mem", t, 11'b1000000_10_00);
        t = idle(); t.rt = 8; t.urt = 1; t.exrw = 8; t.exwr = 1;
        add("add_sub", t, 11'b1000000_00_00);
        t = idle();                                                 add("sub_fwd_ex", t, 11'b1000000_00_01);
        t = idle(); t.rs = 7; t.urs = 1; t.exrw = 7; t.exwr = 1; t.memrw = 7; t.memwr = 1;
        add("ex_over_mem", t, 11'b1000000_00_00);
        t = idle();                                                 add("fwd_ex_prio", t, 11'b1000000_01_00);
        t = idle(); t.rs = 8; t.urs = 1; t.exrw = 8; t.exwr = 1; t.exmrd = 1;
        t.rt = 9; t.urt = 1; t.memrw = 9; t.memwr = 1;
        add("stall_clears_fwd", t, 11'b0101000_00_00);
        t = idle();                                                 add("fwd_zero_after_stall", t, 11'b1000000_00_00);
        t = idle(); t.rs = 8; t.urs = 1; t.exrw = 8; t.exwr = 1; t.exmrd = 1; t.br = 1;
        add("branch_over_load", t, 11'b1011000_00_00);
        t = idle(); t.rs = 8; t.urs = 1; t.exrw = 8; t.exwr = 1; t.exmrd = 1; t.jump = 1;
        add("stall_beats_jump", t, 11'b0101000_00_00);
        t = idle();                                                 add("single_stall", t, 11'b1000000_00_00);
`else
        t = idle(); t.rt = 8; t.urt = 1; t.exrw = 8; t.exwr = 1;
        add("ex_hazard", t, 11'b0101000_00_00);
        t = idle(); t.rt = 8; t.urt = 1; t.memrw = 8; t.memwr = 1;
        add("stall_2nd", t, 11'b0101000_00_00);
        t = idle(); t.rt = 8; t.urt = 1;                            add("stall_done", t, 11'b1000000_00_00);
        t = idle(); t.rs = 9; t.urs = 1; t.memrw = 9; t.memwr = 1;
        add("mem_hazard", t, 11'b0101000_00_00);
        t = idle(); t.rs = 9; t.urs = 1;                            add("mem_done", t, 11'b1000000_00_00);
        t = idle(); t.rs = 5; t.urs = 1; t.exrw = 5; t.exwr = 1; t.jump = 1;
        add("stall_beats_jump", t, 11'b0101000_00_00);
        t = idle(); t.rs = 5; t.urs = 1; t.memrw = 5; t.memwr = 1; t.jump = 1; t.br = 1;
        add("branch_in_stall", t, 11'b1011000_00_00);
        t = idle();                                                 add("run_after_branch", t, 11'b1000000_00_00);
        t = idle(); t.rs = 5; t.urs = 1; t.exrw = 5; t.exwr = 1; t.br = 1;
        add("branch_over_hazard", t, 11'b1011000_00_00);
        t = idle();                                                 add("run_after_branch2", t, 11'b1000000_00_00);
        t = idle(); t.rt = 8; t.urt = 1; t.exrw = 8; t.exwr = 1;
        add("stall_then_reset", t, 11'b0101000_00_00);
        t = idle(); t.rst = 1'b0;                                   add("reset_in_stall", t, 11'b0011100_00_00);
        t = idle();                                                 add("after_stall_reset", t, 11'b1000000_00_00);
`endif

        t = idle(); t.rst = 1'b0;
        apply(t);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #2;
            apply(vecs[i].stim);
            #1;
            check(vecs[i].name, obs, vecs[i].exp);
        end

        // Hand sequence: IRQ held high must be taken exactly one cycle after sampling.
        @(posedge clk); #2;
        t = idle(); t.irq = 1; apply(t);
        found = -1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (IRQ_Take === 1'b1) begin
                found = k;
                break;
            end
            @(posedge clk); #2;
        end
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL irq_take_latency: got %0d expected 1 (-1 = timeout)", found);
        end
        @(posedge clk); #2;
        t = idle(); apply(t); #1;
        check("kernel_entered", obs, 11'b1000001_00_00);
        @(posedge clk); #2;
        t = idle(); t.eret = 1; apply(t); #1;
        check("eret_cycle", obs, 11'b1000001_00_00);
        @(posedge clk); #2;
        t = idle(); apply(t); #1;
        check("kernel_left", obs, 11'b1000000_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
